// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed load/store requests into word-wide
// RAM strobes. Sub-word stores use read-modify-write. Each request ends
// with a one-cycle done pulse, plus err if the request was rejected.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   reqValid/reqReady request handshake (accepted only while idle)
//   reqWrite, reqSize, reqSigned, reqAddr, reqWData  request fields
//   done, err, rdata  completion pulse, reject flag, load result
//   memRead, memWrite, memAddr, memWData, memRData   word RAM interface
module load_store_unit #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqWData,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        memRead,
    output logic        memWrite,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    input  logic [31:0] memRData
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state;
    logic [1:0]  latSize;
    logic        latSigned;
    logic [1:0]  latLane;
    logic [31:0] latWData;

    logic        reqErr;
    logic [7:0]  laneByte;
    logic [15:0] laneHalf;
    logic [31:0] loadResult;
    logic [31:0] mergedWord;

    // Reject illegal sizes, misaligned accesses and addresses beyond the RAM.
    always_comb begin
        reqErr = 1'b0;
        case (reqSize)
            2'b01:   reqErr = reqAddr[0];
            2'b10:   reqErr = |reqAddr[1:0];
            2'b11:   reqErr = 1'b1;
            default: reqErr = 1'b0;
        endcase
        if (reqAddr[31:ADDR_W+2] != '0) begin
            reqErr = 1'b1;
        end
    end

    // Extract and extend the addressed lane of the word being read.
    always_comb begin
        laneByte   = 8'(memRData >> {latLane, 3'b000});
        laneHalf   = latLane[1] ? memRData[31:16] : memRData[15:0];
        loadResult = memRData;
        case (latSize)
            2'b00:   loadResult = latSigned ? {{24{laneByte[7]}}, laneByte}
                                            : {24'd0, laneByte};
            2'b01:   loadResult = latSigned ? {{16{laneHalf[15]}}, laneHalf}
                                            : {16'd0, laneHalf};
            default: loadResult = memRData;
        endcase
    end

    // Replace the addressed lane of the old word with the store data.
    always_comb begin
        mergedWord = memRData;
        if (latSize == 2'b00) begin
            case (latLane)
                2'd0:    mergedWord[7:0]   = latWData[7:0];
                2'd1:    mergedWord[15:8]  = latWData[7:0];
                2'd2:    mergedWord[23:16] = latWData[7:0];
                default: mergedWord[31:24] = latWData[7:0];
            endcase
        end else if (latSize == 2'b01) begin
            if (latLane[1]) begin
                mergedWord[31:16] = latWData[15:0];
            end else begin
                mergedWord[15:0] = latWData[15:0];
            end
        end else begin
            mergedWord = latWData;
        end
    end

    // Control FSM; every output is registered and set on entry to its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            reqReady  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            memRead   <= 1'b0;
            memWrite  <= 1'b0;
            memAddr   <= '0;
            memWData  <= '0;
            latSize   <= '0;
            latSigned <= 1'b0;
            latLane   <= '0;
            latWData  <= '0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            memRead  <= 1'b0;
            memWrite <= 1'b0;
            case (state)
                IDLE: begin
                    if (reqValid) begin
                        latSize   <= reqSize;
                        latSigned <= reqSigned;
                        latLane   <= reqAddr[1:0];
                        latWData  <= reqWData;
                        memAddr   <= 32'(reqAddr[ADDR_W+1:2]);
                        reqReady  <= 1'b0;
                        if (reqErr) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (!reqWrite) begin
                            state   <= LOAD;
                            memRead <= 1'b1;
                        end else if (reqSize == 2'b10) begin
                            state    <= STORE;
                            memWrite <= 1'b1;
                            memWData <= reqWData;
                        end else begin
                            state   <= RMW_RD;
                            memRead <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    rdata <= loadResult;
                    done  <= 1'b1;
                    state <= DONE;
                end
                STORE: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                RMW_RD: begin
                    memWData <= mergedWord;
                    memWrite <= 1'b1;
                    state    <= RMW_WR;
                end
                RMW_WR: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    reqReady <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    reqReady <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word RAM model driven by the DUT strobes,
// byte-array reference model, directed cases plus 500 random requests.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqSigned;
    logic [31:0] reqAddr;
    logic [31:0] reqWData;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        memRead;
    logic        memWrite;
    logic [31:0] memAddr;
    logic [31:0] memWData;
    logic [31:0] memRData;

    load_store_unit #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr),
        .reqWData(reqWData), .done(done), .err(err), .rdata(rdata),
        .memRead(memRead), .memWrite(memWrite), .memAddr(memAddr),
        .memWData(memWData), .memRData(memRData)
    );

    always #5 clk = ~clk;

    // RAM seen by the DUT; the bench preloads it through a side port.
    logic [31:0] ram [256];
    logic        tbWe = 1'b0;
    logic [7:0]  tbIdx = 8'd0;
    logic [31:0] tbData = 32'd0;
    assign memRData = ram[memAddr[7:0]];
    always @(posedge clk) begin
        if (tbWe) ram[tbIdx] <= tbData;
        else if (memWrite) ram[memAddr[7:0]] <= memWData;
    end

    // Reference model.
    logic [7:0]  refMem [1024];
    logic [31:0] refRdata;

    int passCnt = 0;
    int checkCnt = 0;
    int failCnt = 0;
    int acceptCnt = 0;
    int doneCnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst && reqValid && reqReady) acceptCnt++;
        if (!rst && done) doneCnt++;
    end

    always @(negedge clk) begin
        chk("strobe_excl", 32'(memRead & memWrite), 32'd0);
        if (memRead | memWrite) chk("addr_range", 32'(memAddr[31:8]), 32'd0);
    end

    function automatic logic [31:0] refWord(input int idx);
        logic [31:0] v = 0;
        for (int b = 0; b < 4; b++) v |= 32'(refMem[4*idx+b]) << (8*b);
        return v;
    endfunction

    function automatic logic [31:0] refLoad(input int n, input logic sg, input logic [31:0] a);
        logic [31:0] v = 0;
        for (int i = 0; i < n; i++) v |= 32'(refMem[int'(a)+i]) << (8*i);
        if (sg && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8*n);
        return v;
    endfunction

    // Called at a negedge; returns at a negedge.
    task automatic setWord(input int idx, input logic [31:0] val);
        for (int b = 0; b < 4; b++) refMem[4*idx+b] = val[8*b +: 8];
        tbWe = 1'b1; tbIdx = 8'(idx); tbData = val;
        @(posedge clk);
        @(negedge clk);
        tbWe = 1'b0;
    endtask

    // Issue one request at a negedge and check it end to end; returns at the
    // negedge after done, which is when the next request may be driven.
    task automatic doReq(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        int n, expLat, expR, expW, nR, nW, lat;
        logic e, seen;
        logic [31:0] expWord;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e = (sz == 2'd3) || (a % n != 0) || (a >= 32'd1024);
        expWord = 32'd0;
        if (e) begin
            expLat = 1; expR = 0; expW = 0;
        end else if (!w) begin
            expLat = 2; expR = 1; expW = 0;
            refRdata = refLoad(n, sg, a);
        end else begin
            for (int i = 0; i < n; i++) refMem[int'(a)+i] = wd[8*i +: 8];
            expWord = refWord(int'(a >> 2));
            expLat = (n == 4) ? 2 : 3; expR = (n == 4) ? 0 : 1; expW = 1;
        end
        chk("req_ready", 32'(reqReady), 32'd1);
        reqValid = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg;
        reqAddr = a; reqWData = wd;
        @(posedge clk);
        @(negedge clk);
        reqValid = 1'b0;
        reqWData = $urandom;
        reqAddr = $urandom;
        nR = 0; nW = 0; lat = 0; seen = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (memRead) begin
                nR++;
                chk("rd_addr", memAddr, 32'(a[9:2]));
            end
            if (memWrite) begin
                nW++;
                chk("wr_addr", memAddr, 32'(a[9:2]));
                chk("wr_data", memWData, expWord);
            end
            if (done) begin
                seen = 1'b1; lat = k;
                break;
            end
            @(negedge clk);
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'(expLat));
        chk("err", 32'(err), 32'(e));
        chk("rdata", rdata, refRdata);
        chk("n_read", 32'(nR), 32'(expR));
        chk("n_write", 32'(nW), 32'(expW));
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("ready_after", 32'(reqReady), 32'd1);
    endtask

    initial begin
        int mism, acc0;
        logic w, sg;
        logic [1:0] sz;
        logic [31:0] a;
        int n;
        rst = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'd0;
        reqSigned = 1'b0; reqAddr = 32'd0; reqWData = 32'd0;
        refRdata = 32'd0;
        @(negedge clk);
        for (int i = 0; i < 256; i++) setWord(i, $urandom);

        // Reset values
        chk("rst_ready", 32'(reqReady), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_memRead", 32'(memRead), 32'd0);
        chk("rst_memWrite", 32'(memWrite), 32'd0);
        chk("rst_memAddr", memAddr, 32'd0);
        chk("rst_memWData", memWData, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Word store then load back
        doReq(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        doReq(1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
        chk("lw_lit", rdata, 32'hDEAD_BEEF);

        // Byte store via read-modify-write
        setWord(4, 32'h1122_3344);
        doReq(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_00A5);
        chk("sb_ram_lit", ram[4], 32'h11A5_3344);

        // Sub-word loads with extension
        setWord(0, 32'h8081_F0F7);
        doReq(1'b0, 2'd0, 1'b1, 32'h0, 32'd0);
        chk("lb_lit", rdata, 32'hFFFF_FFF7);
        doReq(1'b0, 2'd0, 1'b0, 32'h3, 32'd0);
        chk("lbu_lit", rdata, 32'h0000_0080);
        doReq(1'b0, 2'd1, 1'b1, 32'h2, 32'd0);
        chk("lh_lit", rdata, 32'hFFFF_8081);
        doReq(1'b0, 2'd1, 1'b0, 32'h0, 32'd0);
        chk("lhu_lit", rdata, 32'h0000_F0F7);

        // Rejected requests
        doReq(1'b0, 2'd1, 1'b0, 32'h5, 32'd0);
        doReq(1'b1, 2'd2, 1'b0, 32'h6, 32'h1234_5678);
        doReq(1'b0, 2'd3, 1'b0, 32'h8, 32'd0);
        doReq(1'b0, 2'd2, 1'b0, 32'h400, 32'd0);
        chk("err_rdata_kept", rdata, 32'h0000_F0F7);

        // reqValid held high: second request only after done
        acc0 = acceptCnt;
        reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'd2; reqSigned = 1'b0;
        reqAddr = 32'h0;
        @(posedge clk); @(negedge clk);
        chk("hold_k1_ready", 32'(reqReady), 32'd0);
        @(negedge clk);
        chk("hold_k2_done", 32'(done), 32'd1);
        chk("hold_k2_ready", 32'(reqReady), 32'd0);
        @(negedge clk);
        chk("hold_k3_ready", 32'(reqReady), 32'd1);
        chk("hold_accepts1", 32'(acceptCnt - acc0), 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("hold_k5_done", 32'(done), 32'd1);
        reqValid = 1'b0;
        refRdata = refWord(0);
        chk("hold_rdata", rdata, refRdata);
        @(negedge clk);
        chk("hold_accepts2", 32'(acceptCnt - acc0), 32'd2);

        // Reset during RMW read phase
        setWord(7, 32'h1122_3344);
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd0; reqSigned = 1'b0;
        reqAddr = 32'h1C; reqWData = 32'h0000_00FF;
        @(posedge clk); @(negedge clk);
        reqValid = 1'b0;
        chk("abort_memRead", 32'(memRead), 32'd1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        refRdata = 32'd0;
        chk("abort_ready", 32'(reqReady), 32'd1);
        chk("abort_rdata", rdata, 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("abort_no_write", 32'(memWrite), 32'd0);
            chk("abort_no_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        chk("abort_ram", ram[7], 32'h1122_3344);

        // Random requests
        for (int i = 0; i < 500; i++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            a  = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) a = a & ~32'(n - 1);
            if ($urandom_range(0, 15) == 0) a = a | (32'h400 << $urandom_range(0, 21));
            sg = 1'($urandom_range(0, 1));
            doReq(w, sz, sg, a, $urandom);
        end

        mism = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== refWord(i)) mism++;
        chk("ram_final", 32'(mism), 32'd0);
        chk("done_vs_accept", 32'(doneCnt), 32'(acceptCnt - 1));

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
